// File: rtl/data_mem_mmio.sv
// Data-port responder for a single-cycle CPU: word RAM, GPIO register, TX byte FIFO and cycle counter.
// Loads are combinational (0 cycles), stores commit on the edge; the TX FIFO drains with valid/ready.
module data_mem_mmio #(
   parameter int DEPTH_WORDS = 1024,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] ReadData,
   output logic [31:0] gpio_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [29:0] GPIO_W   = 30'h0400_0000;
   localparam logic [29:0] TX_W     = 30'h0400_0001;
   localparam logic [29:0] STATUS_W = 30'h0400_0002;
   localparam logic [29:0] CNT_W    = 30'h0400_0003;

   logic [31:0]   ram_q [DEPTH_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [AW-1:0] ram_idx;

   logic [31:0]   gpio_q, gpio_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic sel_ram, sel_gpio, sel_tx, sel_status, sel_cnt;
   logic full, empty, pop, push_req, push_ok;
   logic [31:0] status_word;
   logic [31:0] read_data;
   logic unused_addr_bits;

   // Byte-offset bits never take part in decoding.
   assign unused_addr_bits = ^A[1:0];

   assign ram_idx    = A[AW+1:2];
   assign sel_ram    = (A[31:28] == 4'h0);
   assign sel_gpio   = (A[31:2] == GPIO_W);
   assign sel_tx     = (A[31:2] == TX_W);
   assign sel_status = (A[31:2] == STATUS_W);
   assign sel_cnt    = (A[31:2] == CNT_W);

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = !empty && tx_ready;
   assign push_req = mem_write && sel_tx;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok  = push_req && (!full || pop);

   assign status_word = {16'h0, 8'(count_q), 5'h0, ovf_q, empty, full};

   always_comb begin
      read_data = '0;
      if (sel_ram)         read_data = ram_q[ram_idx];
      else if (sel_gpio)   read_data = gpio_q;
      else if (sel_status) read_data = status_word;
      else if (sel_cnt)    read_data = cnt_q;
   end

   always_comb begin
      gpio_d   = gpio_q;
      cnt_d    = cnt_q + 32'd1;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (mem_write && sel_gpio) gpio_d = WD;
      if (mem_write && sel_cnt)  cnt_d  = WD;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (mem_write && sel_status && WD[2]) ovf_d = 1'b0;
      if (push_req && !push_ok)             ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpio_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         gpio_q   <= gpio_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_write && sel_ram) ram_q[ram_idx] <= WD;
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= WD[7:0];
   end

   assign ReadData = read_data;
   assign gpio_out = gpio_q;
   assign tx_data  = fifo_q[rd_ptr_q];
   assign tx_valid = !empty;
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, GPIO, TX FIFO, counter, unmapped accesses and reset.
module tb_data_mem_mmio;
   localparam logic [31:0] GPIO_A   = 32'h1000_0000;
   localparam logic [31:0] TX_A     = 32'h1000_0004;
   localparam logic [31:0] STATUS_A = 32'h1000_0008;
   localparam logic [31:0] CNT_A    = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] WD = '0;
   logic [31:0] ReadData;
   logic [31:0] gpio_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;

   int pass_cnt = 0;
   int total    = 0;

   data_mem_mmio #(.DEPTH_WORDS(1024), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .mem_write(mem_write), .A(A), .WD(WD),
      .ReadData(ReadData), .gpio_out(gpio_out), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      mem_write = 1'b1; A = addr; WD = data;
      @(posedge clk); #1;
      mem_write = 1'b0;
   endtask

   task automatic set_read(input logic [31:0] addr);
      mem_write = 1'b0; A = addr; #1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (gpio_out !== 32'h0) $display("FAIL rst_gpio_out got=%h exp=0", gpio_out); else pass_cnt++;
      total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); else pass_cnt++;
      set_read(GPIO_A);
      total++; if (ReadData !== 32'h0) $display("FAIL rst_rd_gpio got=%h exp=0", ReadData); else pass_cnt++;
      set_read(CNT_A);
      total++; if (ReadData !== 32'h0) $display("FAIL rst_rd_cnt got=%h exp=0", ReadData); else pass_cnt++;
      set_read(TX_A);
      total++; if (ReadData !== 32'h0) $display("FAIL rst_rd_tx got=%h exp=0", ReadData); else pass_cnt++;
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h2) $display("FAIL rst_rd_status got=%h exp=00000002", ReadData); else pass_cnt++;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ram();
      do_write(32'h0000_0010, 32'hDEAD_BEEF);
      set_read(32'h0000_0010);
      total++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL ram_load got=%h exp=deadbeef", ReadData); else pass_cnt++;
      set_read(32'h0000_0011);
      total++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL ram_byte_off got=%h exp=deadbeef", ReadData); else pass_cnt++;
      set_read(32'h0000_1010);
      total++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL ram_alias got=%h exp=deadbeef", ReadData); else pass_cnt++;
      @(posedge clk); #1;
      mem_write = 1'b1; A = 32'h0000_0010; WD = 32'h1234_5678; #1;
      total++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL ram_same_cycle got=%h exp=deadbeef", ReadData); else pass_cnt++;
      @(posedge clk); #1;
      mem_write = 1'b0; #1;
      total++; if (ReadData !== 32'h1234_5678) $display("FAIL ram_overwrite got=%h exp=12345678", ReadData); else pass_cnt++;
      do_write(32'h0000_0014, 32'hCAFE_0001);
      set_read(32'h0000_0010);
      total++; if (ReadData !== 32'h1234_5678) $display("FAIL ram_neighbour got=%h exp=12345678", ReadData); else pass_cnt++;
   endtask

   task automatic test_gpio_reset();
      @(posedge clk); #1;
      do_write(GPIO_A, 32'h0000_00A5);
      total++; if (gpio_out !== 32'h0000_00A5) $display("FAIL gpio_out got=%h exp=000000a5", gpio_out); else pass_cnt++;
      set_read(GPIO_A);
      total++; if (ReadData !== 32'h0000_00A5) $display("FAIL gpio_read got=%h exp=000000a5", ReadData); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total++; if (gpio_out !== 32'h0) $display("FAIL gpio_async_rst got=%h exp=0", gpio_out); else pass_cnt++;
      #1 rst = 1'b1;
   endtask

   task automatic test_counter();
      logic [31:0] exp_c;
      @(posedge clk); #1;
      set_read(CNT_A);
      for (int i = 1; i <= 3; i++) begin
         exp_c = i;
         total++; if (ReadData !== exp_c) $display("FAIL cnt_incr got=%h exp=%h", ReadData, exp_c); else pass_cnt++;
         @(posedge clk); #1;
      end
      do_write(CNT_A, 32'hFFFF_FFFE);
      set_read(CNT_A);
      total++; if (ReadData !== 32'hFFFF_FFFE) $display("FAIL cnt_load got=%h exp=fffffffe", ReadData); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (ReadData !== 32'hFFFF_FFFF) $display("FAIL cnt_load_p1 got=%h exp=ffffffff", ReadData); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (ReadData !== 32'h0) $display("FAIL cnt_wrap got=%h exp=0", ReadData); else pass_cnt++;
   endtask

   task automatic test_fifo();
      logic [7:0] exp_q [8];
      logic [7:0] b;
      tx_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i <= 8; i++) begin
         b = 8'(i);
         do_write(TX_A, {24'h0, b});
      end
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h0000_0801) $display("FAIL fifo_full_status got=%h exp=00000801", ReadData); else pass_cnt++;
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) $display("FAIL fifo_head got=%b/%h exp=1/01", tx_valid, tx_data); else pass_cnt++;
      set_read(TX_A);
      total++; if (ReadData !== 32'h0) $display("FAIL tx_data_read got=%h exp=0", ReadData); else pass_cnt++;
      do_write(TX_A, 32'h0000_0009);
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h0000_0805) $display("FAIL fifo_overflow got=%h exp=00000805", ReadData); else pass_cnt++;
      do_write(STATUS_A, 32'h0000_0004);
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h0000_0801) $display("FAIL ovf_clear got=%h exp=00000801", ReadData); else pass_cnt++;

      mem_write = 1'b1; A = TX_A; WD = 32'h0000_0055; tx_ready = 1'b1;
      @(posedge clk); #1;
      mem_write = 1'b0; tx_ready = 1'b0;
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h0000_0801) $display("FAIL push_pop_full got=%h exp=00000801", ReadData); else pass_cnt++;

      exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
      exp_q[4] = 8'h06; exp_q[5] = 8'h07; exp_q[6] = 8'h08; exp_q[7] = 8'h55;
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
            $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      total++; if (tx_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", tx_valid); else pass_cnt++;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      total++; if (ReadData !== 32'h0000_0002) $display("FAIL drain_status got=%h exp=00000002", ReadData); else pass_cnt++;

      mem_write = 1'b1; A = TX_A; WD = 32'h0000_00AB; #1;
      total++; if (tx_valid !== 1'b0) $display("FAIL valid_before_edge got=%b exp=0", tx_valid); else pass_cnt++;
      @(posedge clk); #1;
      mem_write = 1'b0;
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'hAB) $display("FAIL valid_rise got=%b/%h exp=1/ab", tx_valid, tx_data); else pass_cnt++;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      total++; if (tx_valid !== 1'b0) $display("FAIL valid_fall got=%b exp=0", tx_valid); else pass_cnt++;
   endtask

   task automatic test_unmapped();
      do_write(GPIO_A, 32'h0000_003C);
      do_write(32'h0000_0000, 32'h1111_2222);
      do_write(CNT_A, 32'h0000_1000);
      do_write(32'h2000_0000, 32'hFFFF_FFFF);
      set_read(CNT_A);
      total++; if (ReadData !== 32'h0000_1001) $display("FAIL unmapped_cnt got=%h exp=00001001", ReadData); else pass_cnt++;
      set_read(32'h2000_0000);
      total++; if (ReadData !== 32'h0) $display("FAIL unmapped_read got=%h exp=0", ReadData); else pass_cnt++;
      total++; if (gpio_out !== 32'h0000_003C) $display("FAIL unmapped_gpio got=%h exp=0000003c", gpio_out); else pass_cnt++;
      set_read(32'h0000_0000);
      total++; if (ReadData !== 32'h1111_2222) $display("FAIL unmapped_ram0 got=%h exp=11112222", ReadData); else pass_cnt++;
      set_read(STATUS_A);
      total++; if (ReadData !== 32'h0000_0002) $display("FAIL unmapped_status got=%h exp=00000002", ReadData); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ram();
      test_gpio_reset();
      test_counter();
      test_fifo();
      test_unmapped();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Memory-side responder for the single-cycle CPU's data port. It consumes `mem_write`, `A`, `WD` and returns `ReadData`. It decodes `A` into four targets:
- a word-addressed data RAM;
- a GPIO output register;
- a transmit FIFO with valid/ready drain to an external consumer;
- a free-running cycle counter.

Reads are combinational so the CPU completes a load in one cycle; all writes commit on the rising clock edge.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  store strobe from CPU.
- `A`  in  32  byte address from CPU.
- `WD`  in  32  store data from CPU.
- `ReadData`  out  32  load data to CPU; combinational.
- `gpio_out`  out  32  GPIO output register.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts head this cycle.

## Operation
Address map (decode on full `A`; `A[1:0]` ignored everywhere):
- RAM region:
  - Selected when `A[31:28]==4'h0`.
  - Word index = `A[log2(DEPTH_WORDS)+1:2]`; higher bits inside the region alias (wrap modulo DEPTH_WORDS).
  - Read returns the word; a write stores `WD`.
- `0x1000_0000` GPIO: read returns `gpio_out`; write loads `WD`.
- `0x1000_0004` TX_DATA:
  - Read returns 0.
  - Write pushes `WD[7:0]`.
- `0x1000_0008` STATUS, read value:
  - bit0 = full, bit1 = empty, bit2 = overflow (sticky).
  - bits[15:8] = FIFO count.
  - All other bits 0.
- Write to STATUS: if `WD[2]==1`, clear overflow; other bits ignored.
- `0x1000_000C` COUNTER:
  - Read returns the current count.
  - Write loads `WD`.
- Any other address: read returns 0, write has no effect.

FIFO rules:
- Push is accepted when `count<FIFO_DEPTH`, or when a pop occurs in the same cycle.
- A rejected push drops the byte and sets overflow.
- Pop occurs when `tx_valid && tx_ready`. `tx_ready` while empty has no effect.
- `tx_valid = (count!=0)`. `tx_data` is the head entry, valid only when `tx_valid=1`.
- Pointers wrap modulo FIFO_DEPTH. Count is kept separately: 0..FIFO_DEPTH, `$clog2(FIFO_DEPTH)+1` bits.
- A simultaneous push and pop leaves count unchanged and writes the tail.
- Overflow set and a STATUS clear in the same cycle: set wins.

Counter rules:
- Increments by 1 every cycle out of reset.
- Wraps from `0xFFFF_FFFF` to `0`.
- A write-load wins over the increment that cycle; the next cycle reads `WD`, the cycle after that reads `WD+1`.

Reset (asserted, asynchronous):
- `gpio_out=0`, counter=0.
- FIFO pointers and count = 0, so `tx_valid=0` and overflow=0.
- RAM contents are not reset; they keep prior values, X after power-up in simulation.
- `ReadData` follows `A` combinationally, so it reads 0 for GPIO/counter/TX_DATA and `0x0000_0002` for STATUS.

Reset mid-operation empties the FIFO immediately; queued bytes are lost.

## Timing
- Load latency: 0 cycles. `ReadData` reflects registered state before the current edge.
- A store takes effect at the edge. A load of the same address in the next cycle sees the new value.
- A load and a store to the same address in the same cycle return the old value.
- `tx_valid` rises one cycle after the first accepted push into an empty FIFO.
- `tx_valid` falls in the cycle after the last pop.
- There is no combinational path from `tx_ready` to `ReadData` or `tx_valid`.

## Test plan
- RAM store/load: write `0xDEADBEEF` at `0x0000_0010`, read `0x0000_0010` next cycle -> `0xDEADBEEF`. Read `0x0000_0011` -> same. Read `0x0000_0010+4*DEPTH_WORDS` -> same (alias).
- GPIO and reset:
  - Write `0x0000_00A5` to GPIO -> `gpio_out=0x0000_00A5` after the edge.
  - Assert `rst` low between edges -> `gpio_out=0` immediately.
- FIFO fill/overflow/drain with `tx_ready=0`:
  - Push bytes `0x01`..`0x08` -> STATUS=`0x0000_0801`.
  - Push a 9th byte -> dropped, STATUS=`0x0000_0805`.
  - Write STATUS `0x4` -> overflow clears.
  - Raise `tx_ready` -> `tx_data` presents `0x01`..`0x08` in order, one per cycle, then `tx_valid=0` and STATUS=`0x0000_0002`.
- Full FIFO, simultaneous push+pop: push `0x55` while `tx_ready=1` -> accepted, count stays 8, overflow stays 0, `0x55` drains last.
- Counter:
  - Read COUNTER over 3 consecutive cycles after reset -> strictly +1 per cycle.
  - Write `0xFFFF_FFFE` -> reads `0xFFFF_FFFE`, then `0xFFFF_FFFF`, then `0x0000_0000`.
- Unmapped address: write to `0x2000_0000`, then read it -> `0`. No change to GPIO, FIFO, counter, or RAM word 0.
